// File: rtl/adder_bist_driver.sv
// adder_bist_driver
//   Built-in self-test driver for an external pipelined adder. After a start
//   request it does three things:
//     - issues num_vec pseudo-random operand pairs, drawn from a 32-bit LFSR
//     - delays each expected sum by LATENCY cycles
//     - compares each delayed sum against the adder's response
//   It counts mismatching vectors and records the index of the first one.
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous active-high reset
//   start          one-cycle run request, honoured only in IDLE or DONE
//   seed           LFSR seed, captured with start (0 is treated as 1)
//   num_vec        number of vectors, captured with start
//   dut_a, dut_b   registered operands driven to the adder under test
//   dut_sum        sum returned by the adder under test
//   dut_cout       carry-out returned by the adder under test
//   busy           high while issuing vectors or draining the pipeline
//   done           high once the run has completed
//   pass           valid while done: 1 when no mismatch was seen
//   err_count      saturating count of mismatching vectors
//   first_err_idx  0-based index of the first mismatching vector (0 if none)
module adder_bist_driver #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [15:0]      num_vec,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      first_err_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Fibonacci LFSR, polynomial x^32 + x^22 + x^2 + x + 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t        state;
  logic [31:0]   lfsr;
  logic [15:0]   num_vec_r;
  logic [15:0]   vec_cnt;    // vectors issued so far in this run
  logic [3:0]    drain_cnt;
  logic          cur_vld;    // dut_a/dut_b carry a fresh vector this cycle
  logic [15:0]   cur_idx;    // index of the vector on dut_a/dut_b

  logic          vld_p [LATENCY];
  logic [WIDTH:0] exp_p [LATENCY];
  logic [15:0]   idx_p [LATENCY];

  logic [31:0]   seed_eff;
  logic [WIDTH:0] exp_in;
  logic [WIDTH:0] resp;
  logic          mismatch;
  logic [15:0]   err_next;

  always_comb begin
    seed_eff = (seed == 32'd0) ? 32'd1 : seed;
    exp_in   = {1'b0, dut_a} + {1'b0, dut_b};
    resp     = {dut_cout, dut_sum};
    mismatch = vld_p[LATENCY-1] && (resp != exp_p[LATENCY-1]);
    err_next = mismatch ? sat_inc(err_count) : err_count;
  end

  // Stage boundary: presented vector -> delay line (expected sum and index).
  always_ff @(posedge clk) begin
    exp_p[0] <= exp_in;
    idx_p[0] <= cur_idx;
    for (int j = 1; j < LATENCY; j++) begin
      exp_p[j] <= exp_p[j-1];
      idx_p[j] <= idx_p[j-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lfsr          <= 32'd1;
      dut_a         <= '0;
      dut_b         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      num_vec_r     <= '0;
      vec_cnt       <= '0;
      drain_cnt     <= '0;
      cur_vld       <= 1'b0;
      cur_idx       <= '0;
      for (int j = 0; j < LATENCY; j++) vld_p[j] <= 1'b0;
    end else begin
      // Stage boundary: valid bits shift alongside the data delay line.
      vld_p[0] <= cur_vld;
      for (int j = 1; j < LATENCY; j++) vld_p[j] <= vld_p[j-1];

      // Compare stage: oldest delay-line slot against the adder response.
      if (mismatch) begin
        err_count <= err_next;
        if (err_count == 16'd0) first_err_idx <= idx_p[LATENCY-1];
      end

      unique case (state)
        IDLE, DONE: begin
          cur_vld <= 1'b0;
          if (start) begin
            num_vec_r     <= num_vec;
            err_count     <= '0;
            first_err_idx <= '0;
            for (int j = 0; j < LATENCY; j++) vld_p[j] <= 1'b0;
            if (num_vec == 16'd0) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              // Vector 0 is the seed itself; the LFSR moves one step ahead.
              state   <= RUN;
              busy    <= 1'b1;
              done    <= 1'b0;
              pass    <= 1'b0;
              dut_a   <= seed_eff[WIDTH-1:0];
              dut_b   <= seed_eff[2*WIDTH-1:WIDTH];
              lfsr    <= lfsr_next(seed_eff);
              cur_vld <= 1'b1;
              cur_idx <= '0;
              vec_cnt <= 16'd1;
            end
          end
        end
        RUN: begin
          if (vec_cnt == num_vec_r) begin
            state     <= DRAIN;
            cur_vld   <= 1'b0;
            drain_cnt <= '0;
          end else begin
            dut_a   <= lfsr[WIDTH-1:0];
            dut_b   <= lfsr[2*WIDTH-1:WIDTH];
            lfsr    <= lfsr_next(lfsr);
            cur_vld <= 1'b1;
            cur_idx <= vec_cnt;
            vec_cnt <= vec_cnt + 16'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt == 4'(LATENCY-1)) begin
            // The last vector is compared in this cycle, so pass uses err_next.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 16'd0);
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
